debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
Parametrised multi-channel debouncer for front-panel buttons.
- Each channel is synchronised to clk and qualified against a shared sample tick. The tick comes from a clock-enable prescaler, not a divided clock, so all logic runs on clk.
- Each channel produces:
  - a clean level,
  - single-cycle press and release pulses,
  - a held flag,
  - an auto-repeat pulse train for time/alarm set buttons.
- Sits between the raw button pins and the clock-setting control FSM.

Parameters:
- CHANNELS, 4: number of independent button channels (>=1).
- TICK_COUNT, 32'h17D784: clk cycles per sample tick (>=2).
- STABLE_TICKS, 3: consecutive ticks a new value must persist before being accepted (>=1).
- REPEAT_DELAY, 32: ticks after acceptance of press before first repeat; 0 disables held and repeat.
- REPEAT_RATE, 8: ticks between subsequent repeats (>=1).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- btn_in, in, CHANNELS: raw asynchronous button inputs, active-high.
- btn_level, out, CHANNELS: debounced level.
- btn_rise, out, CHANNELS: 1-clk pulse when level goes 0->1.
- btn_fall, out, CHANNELS: 1-clk pulse when level goes 1->0.
- btn_held, out, CHANNELS: high while level=1 and REPEAT_DELAY reached.
- btn_press, out, CHANNELS: btn_rise OR repeat pulse (1 clk each).
- tick, out, 1: sample-tick strobe, exported for reuse.

Behaviour:
- Reset (async assert; deassert is synchronous to clk): all outputs 0, prescaler 0, all sync FFs 0, levels 0, all counters 0.
- Prescaler: counts 0..TICK_COUNT-1 and wraps. tick=1 for exactly the cycle in which count==TICK_COUNT-1. Counter width is $clog2(TICK_COUNT).
- Synchroniser: 2 FFs per channel on clk; sync = second stage. No tick gating.
- Per channel, on each tick cycle:
  - If sync==level, stable counter := 0.
  - Else if counter==STABLE_TICKS-1, then level := sync and counter := 0.
  - Else counter++.
  - Non-tick cycles: counter holds.
- Edge pulses:
  - btn_rise/btn_fall are registered and asserted in the cycle after level changes, for 1 clk.
  - They never both assert in the same cycle on one channel.
- Repeat (REPEAT_DELAY>0), hold counter per channel:
  - Cleared to 0 on the rise update.
  - While level=1, increments on each tick, saturating at REPEAT_DELAY.
  - On the tick where it reaches REPEAT_DELAY: btn_held := 1, repeat pulse fires, rate counter := 0.
  - Thereafter, rate counter increments on each tick. When it reaches REPEAT_RATE: repeat pulse fires and rate counter := 0.
  - Repeat pulse is registered and aligned with btn_rise timing (cycle after the tick).
- Release: on the fall update, btn_held := 0 in the same cycle level clears. Hold and rate counters clear and no further repeats fire.
- A glitch shorter than STABLE_TICKS ticks causes no change. Any tick that samples sync==level restarts qualification.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Reset mid-qualification or mid-repeat: everything returns to reset state immediately, with no pulses on release of reset. A button held through reset deassertion is reported as a fresh press after STABLE_TICKS ticks.
- Latency, input edge to rise pulse: 2 clk sync, plus (STABLE_TICKS-1)*TICK_COUNT to STABLE_TICKS*TICK_COUNT clk of qualification, plus 1 clk register.

Decomposition:
- Package debounce_pkg holds:
  - default constants (TICK_COUNT_DEFAULT, STABLE_TICKS_DEFAULT, REPEAT_DELAY_DEFAULT, REPEAT_RATE_DEFAULT);
  - a width helper function (clog2 with a minimum of 1).
- Sub-module debounce_channel:
  - contains the synchroniser, stable counter, hold/rate counters and pulse registers for one button;
  - inputs: tick, btn_in bit; outputs: level, rise, fall, held, press.
- debounce_multi holds the shared prescaler and a generate loop over CHANNELS.

Test Plan (bench parameters TICK_COUNT=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, CHANNELS=4):
- Reset and tick: assert rst for 3 clk, then release. All outputs are 0; tick pulses every 4 clk, first at clk 4 after release.
- Clean press on ch0: btn_in[0] rises and stays high. btn_rise[0] and btn_press[0] pulse once, 11..15 clk after the edge; btn_level[0]=1 from then on.
- Glitch rejection on ch1: drive 1 for 6 clk (spanning ≤2 ticks), then 0. No rise, level, or press on ch1 at any time.
- Auto-repeat on ch0: hold high for 40 ticks. Expect press pulses at rise, then at rise+5 ticks (btn_held goes 1), then every 2 ticks after that. Total press count = 1 + 1 + floor((40-5)/2), checked by scoreboard.
- Release and simultaneity: release ch0 while ch2 is pressed in the same clk. btn_fall[0] and btn_rise[2] pulse in the same cycle; btn_held[0] drops with btn_level[0]; no further press on ch0.
- Reset mid-repeat: assert rst while ch0 is held and repeating. All outputs go 0 asynchronously. After release with ch0 still high, exactly one new btn_rise[0] after qualification and no spurious fall.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults and width helper for the front-panel button debouncer.
package debounce_pkg;

    localparam int TICK_COUNT_DEFAULT   = 32'h17D784;
    localparam int STABLE_TICKS_DEFAULT = 3;
    localparam int REPEAT_DELAY_DEFAULT = 32;
    localparam int REPEAT_RATE_DEFAULT  = 8;

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, tick-qualified level filter,
// registered edge pulses and hold/auto-repeat generation.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic held,
    output logic press
);

    localparam int STABLE_W  = clog2_min1(STABLE_TICKS);
    localparam int HOLD_W    = clog2_min1(REPEAT_DELAY + 1);
    localparam int RATE_W    = clog2_min1(REPEAT_RATE);
    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0]   HOLD_FULL   = HOLD_W'(REPEAT_DELAY);
    localparam logic [RATE_W-1:0]   RATE_LAST   = RATE_W'(REPEAT_RATE - 1);

    logic                sync_meta;
    logic                sync;
    logic [STABLE_W-1:0] stable_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [RATE_W-1:0]   rate_cnt;
    logic                differ;
    logic                accept;

    assign differ = (sync != level);
    assign accept = differ && (stable_cnt == STABLE_LAST);

    // NOTE: every register here uses <= so all updates see pre-edge values,
    // which is what lets rise/held/press land in the same cycle as level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync       <= 1'b0;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            rate_cnt   <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            held       <= 1'b0;
            press      <= 1'b0;
        end else begin
            sync_meta <= btn_in;
            sync      <= sync_meta;
            rise      <= 1'b0;
            fall      <= 1'b0;
            press     <= 1'b0;

            if (tick) begin
                if (!differ) begin
                    stable_cnt <= '0;
                end else if (accept) begin
                    stable_cnt <= '0;
                    level      <= sync;
                    rise       <= sync;
                    fall       <= !sync;
                    press      <= sync;
                    held       <= 1'b0;
                    hold_cnt   <= '0;
                    rate_cnt   <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end

                // A tick that releases the button never produces a repeat.
                if (REPEAT_EN && level && !accept) begin
                    if (!held) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= HOLD_FULL;
                            held     <= 1'b1;
                            press    <= 1'b1;
                            rate_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (rate_cnt == RATE_LAST) begin
                        press    <= 1'b1;
                        rate_cnt <= '0;
                    end else begin
                        rate_cnt <= rate_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: shared clock-enable prescaler feeding
// one independent debounce_channel per button.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TICK_COUNT   = TICK_COUNT_DEFAULT,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic [CHANNELS-1:0] btn_held,
    output logic [CHANNELS-1:0] btn_press,
    output logic                tick
);

    localparam int                 PRESC_W    = clog2_min1(TICK_COUNT);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_COUNT - 1);

    logic [PRESC_W-1:0] presc_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Clock enable, not a derived clock: high for the single cycle at the wrap.
    assign tick = (presc_cnt == PRESC_LAST);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .btn_in(btn_in[i]),
            .level (btn_level[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i]),
            .held  (btn_held[i]),
            .press (btn_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed table, corner-case
// sequences and random button activity against a tick-counting model.
module tb_debounce_multi;

    localparam int CH = 4;
    localparam int TC = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] btn_level, btn_rise, btn_fall, btn_held, btn_press;
    logic          tick;

    debounce_multi #(
        .CHANNELS    (CH),
        .TICK_COUNT  (TC),
        .STABLE_TICKS(ST),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .btn_held (btn_held),
        .btn_press(btn_press),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The debouncer sees btn_in two edges late; a level flips once the
    // input has differed from it on ST ticks in a row; repeats are a pure
    // function of how many ticks have elapsed since the press was accepted.
    logic [CH-1:0] in_hist[$];
    int            m_edges;
    int            m_ticks;
    int            anchor[CH];
    int            rise_tick[CH];
    logic [CH-1:0] m_level;
    logic [CH-1:0] exp_rise, exp_fall, exp_held, exp_press;
    logic          exp_tick;

    task automatic model_reset();
        in_hist.delete();
        in_hist.push_back('0);
        in_hist.push_back('0);
        m_edges   = 0;
        m_ticks   = 0;
        m_level   = '0;
        exp_rise  = '0;
        exp_fall  = '0;
        exp_held  = '0;
        exp_press = '0;
        exp_tick  = 1'b0;
        for (int c = 0; c < CH; c++) begin
            anchor[c]    = 0;
            rise_tick[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] sync_v;
        logic          tick_v;
        sync_v = in_hist.pop_front();
        in_hist.push_back(btn_in);
        tick_v = (m_edges % TC) == TC - 1;
        m_edges++;
        exp_rise  = '0;
        exp_fall  = '0;
        exp_press = '0;
        if (tick_v) begin
            m_ticks++;
            for (int c = 0; c < CH; c++) begin
                bit flipped;
                int k;
                flipped = 1'b0;
                if (sync_v[c] == m_level[c]) begin
                    anchor[c] = m_ticks;
                end else if (m_ticks - anchor[c] == ST) begin
                    anchor[c]  = m_ticks;
                    m_level[c] = sync_v[c];
                    flipped    = 1'b1;
                    if (sync_v[c]) begin
                        exp_rise[c]  = 1'b1;
                        exp_press[c] = 1'b1;
                        rise_tick[c] = m_ticks;
                    end else begin
                        exp_fall[c] = 1'b1;
                    end
                end
                if (!flipped && m_level[c]) begin
                    k = m_ticks - rise_tick[c];
                    if (k == RD || (k > RD && (k - RD) % RR == 0))
                        exp_press[c] = 1'b1;
                end
            end
        end
        exp_tick = (m_edges % TC) == TC - 1;
        for (int c = 0; c < CH; c++)
            exp_held[c] = m_level[c] && (m_ticks - rise_tick[c] >= RD);
    endtask

    task automatic compare_all();
        check("level", btn_level, m_level);
        check("rise",  btn_rise,  exp_rise);
        check("fall",  btn_fall,  exp_fall);
        check("held",  btn_held,  exp_held);
        check("press", btn_press, exp_press);
        check("tick",  tick,      exp_tick);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset(input int clks);
        rst = 1'b1;
        #1;
        check("rst async level", btn_level, 0);
        check("rst async rise",  btn_rise,  0);
        check("rst async fall",  btn_fall,  0);
        check("rst async held",  btn_held,  0);
        check("rst async press", btn_press, 0);
        check("rst async tick",  tick,      0);
        model_reset();
        repeat (clks) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [CH-1:0] btn;
        int            clks;
        logic [CH-1:0] level;
        logic [CH-1:0] rises;
        logic [CH-1:0] falls;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_tick, tick_seen, n, presses, rises0, falls0;
        int dur[CH];
        logic [CH-1:0] rises, falls;
        bit found;

        vecs[0] = '{btn: 4'b0000, clks: 12, level: 4'b0000, rises: 4'b0000, falls: 4'b0000};
        vecs[1] = '{btn: 4'b0001, clks: 20, level: 4'b0001, rises: 4'b0001, falls: 4'b0000};
        vecs[2] = '{btn: 4'b0011, clks: 6,  level: 4'b0001, rises: 4'b0000, falls: 4'b0000};
        vecs[3] = '{btn: 4'b0001, clks: 20, level: 4'b0001, rises: 4'b0000, falls: 4'b0000};
        vecs[4] = '{btn: 4'b0100, clks: 20, level: 4'b0100, rises: 4'b0100, falls: 4'b0001};
        vecs[5] = '{btn: 4'b1100, clks: 20, level: 4'b1100, rises: 4'b1000, falls: 4'b0000};
        vecs[6] = '{btn: 4'b0000, clks: 20, level: 4'b0000, rises: 4'b0000, falls: 4'b1100};

        rst    = 1'b1;
        btn_in = '0;
        model_reset();
        @(negedge clk);
        apply_reset(3);

        // Tick is high during the fourth clock period after release, then every TC.
        first_tick = 0;
        tick_seen  = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (tick) begin
                tick_seen++;
                if (first_tick == 0) first_tick = k;
            end
        end
        check("first tick edge", first_tick, 3);
        check("ticks in 12 clk", tick_seen, 3);

        for (int i = 0; i < 7; i++) begin
            btn_in = vecs[i].btn;
            rises  = '0;
            falls  = '0;
            repeat (vecs[i].clks) begin
                cycle();
                rises |= btn_rise;
                falls |= btn_fall;
            end
            check($sformatf("vec%0d level", i), btn_level, vecs[i].level);
            check($sformatf("vec%0d rises", i), rises, vecs[i].rises);
            check($sformatf("vec%0d falls", i), falls, vecs[i].falls);
        end

        // Clean press on ch0: input edge to rise pulse within 11..15 clk.
        btn_in = 4'b0001;
        n      = 0;
        found  = 1'b0;
        while (!found && n < 40) begin
            cycle();
            n++;
            found = btn_rise[0];
        end
        check("ch0 rise latency in 11..15", found && n >= 11 && n <= 15, 1);
        check("ch0 press with rise", btn_press[0], 1);

        // Auto-repeat over 40 ticks of holding.
        presses = 1;
        repeat (40 * TC) begin
            cycle();
            if (btn_press[0]) presses++;
        end
        check("ch0 repeat press count", presses, 1 + 1 + (40 - RD) / RR);
        check("ch0 held while repeating", btn_held[0], 1);

        // Release ch0 and press ch2 on the same clock.
        btn_in = 4'b0100;
        n      = 0;
        found  = 1'b0;
        while (!found && n < 40) begin
            cycle();
            n++;
            found = btn_fall[0] | btn_rise[2];
        end
        check("release seen in budget", found, 1);
        check("ch0 fall same cycle", btn_fall[0], 1);
        check("ch2 rise same cycle", btn_rise[2], 1);
        check("ch0 level drops", btn_level[0], 0);
        check("ch0 held drops", btn_held[0], 0);
        presses = 0;
        repeat (40) begin
            cycle();
            if (btn_press[0]) presses++;
        end
        check("ch0 no press after release", presses, 0);

        // Reset while ch0 is held and repeating; button stays down through it.
        btn_in = 4'b0001;
        n      = 0;
        found  = 1'b0;
        while (!found && n < 40) begin
            cycle();
            n++;
            found = btn_rise[0];
        end
        check("ch0 repress seen", found, 1);
        repeat (40) cycle();
        check("ch0 held before reset", btn_held[0], 1);
        apply_reset(3);
        rises0 = 0;
        falls0 = 0;
        repeat (60) begin
            cycle();
            if (btn_rise[0]) rises0++;
            if (btn_fall[0]) falls0++;
        end
        check("ch0 fresh rise after reset", rises0, 1);
        check("ch0 no fall after reset", falls0, 0);

        // Random button activity with occasional long holds.
        for (int c = 0; c < CH; c++) dur[c] = $urandom_range(1, 30);
        repeat (2000) begin
            for (int c = 0; c < CH; c++) begin
                if (dur[c] == 0) begin
                    btn_in[c] = ~btn_in[c];
                    dur[c] = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 200)
                                                         : $urandom_range(1, 30);
                end else begin
                    dur[c]--;
                end
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
